mlp_param_writer: RTL and testbench

Streaming parameter loader for the one-neuron MLP datapath. It accepts a serial valid/ready stream of weight and bias words, assembles one neuron's weight row plus bias, and writes it into the parameter memory with `write_en`, `layer_addr` and `neuron_addr`. It is the writer side of the memory read by the neuron FSM (`read_en`, same addressing). Loading covers all M-1 layers × N neurons, then `done` pulses.

---
 rtl/mlp_pkg.sv | 32 +++
 rtl/mlp_param_writer.sv | 147 ++++++++++++++
 tb/tb_mlp_param_writer.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/mlp_pkg.sv
// Shared definitions for the MLP parameter memory: writer FSM states,
// default fixed-point widths and the address width helpers used by writer, memory and FSM.
package mlp_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      WRITE = 2'd2,
      DONE  = 2'd3
   } writer_state_t;

   localparam int DEF_QM = 3;
   localparam int DEF_QN = 5;
   localparam int DEF_WM = 3;
   localparam int DEF_WN = 5;
   localparam int DW     = DEF_QM + DEF_QN;
   localparam int WW     = DEF_WM + DEF_WN;

   // Widths never drop below one bit so a degenerate dimension still yields a legal port.
   function automatic int layer_addr_w(input int m);
      return (m > 2) ? $clog2(m - 1) : 1;
   endfunction

   function automatic int neuron_addr_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic int word_cnt_w(input int n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/mlp_param_writer.sv
// Streaming parameter loader: assembles one neuron's weight row plus bias from a
// valid/ready word stream and issues a single write strobe per neuron.
module mlp_param_writer
   import mlp_pkg::*;
#(
   parameter int M  = 3,
   parameter int N  = 3,
   parameter int QM = 3,
   parameter int QN = 5,
   parameter int WM = 3,
   parameter int WN = 5
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            start,
   input  logic                            s_valid,
   output logic                            s_ready,
   input  logic signed [WM+WN-1:0]         s_data,
   output logic                            write_en,
   output logic [layer_addr_w(M)-1:0]      layer_addr,
   output logic [neuron_addr_w(N)-1:0]     neuron_addr,
   output logic signed [WM+WN-1:0]         w_row [N],
   output logic signed [QM+QN-1:0]         bias,
   output logic                            busy,
   output logic                            done
);

   localparam int WGT_W  = WM + WN;
   localparam int BIAS_W = QM + QN;
   localparam int LA_W   = layer_addr_w(M);
   localparam int NA_W   = neuron_addr_w(N);
   localparam int CNT_W  = word_cnt_w(N);

   writer_state_t            state_q, state_d;
   logic [CNT_W-1:0]         word_cnt_q, word_cnt_d;
   logic [LA_W-1:0]          layer_q, layer_d;
   logic [NA_W-1:0]          neuron_q, neuron_d;
   logic signed [BIAS_W-1:0] bias_q, bias_conv;
   logic                     accept, last_neuron, last_layer;

   assign accept      = (state_q == LOAD) && s_valid;
   assign last_neuron = (neuron_q == NA_W'(N - 1));
   assign last_layer  = (layer_q == LA_W'(M - 2));

   // Bias is re-sized only; the binary point is not moved between WN and QN.
   generate
      if (WGT_W > BIAS_W) begin : g_bias_trunc
         assign bias_conv = s_data[BIAS_W-1:0];
      end else if (WGT_W < BIAS_W) begin : g_bias_sext
         assign bias_conv = {{(BIAS_W - WGT_W){s_data[WGT_W-1]}}, s_data};
      end else begin : g_bias_copy
         assign bias_conv = s_data;
      end
   endgenerate

   for (genvar gi = 0; gi < N; gi++) begin : g_row
      logic signed [WGT_W-1:0] w_q;
      always_ff @(posedge clk) begin
         if (rst) begin
            w_q <= '0;
         end else if (accept && (word_cnt_q == CNT_W'(gi))) begin
            w_q <= s_data;
         end
      end
      assign w_row[gi] = w_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         bias_q <= '0;
      end else if (accept && (word_cnt_q == CNT_W'(N))) begin
         bias_q <= bias_conv;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         word_cnt_q <= '0;
         layer_q    <= '0;
         neuron_q   <= '0;
      end else begin
         state_q    <= state_d;
         word_cnt_q <= word_cnt_d;
         layer_q    <= layer_d;
         neuron_q   <= neuron_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      word_cnt_d = word_cnt_q;
      layer_d    = layer_q;
      neuron_d   = neuron_q;
      s_ready    = 1'b0;
      write_en   = 1'b0;
      busy       = 1'b0;
      done       = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d    = LOAD;
               word_cnt_d = '0;
               layer_d    = '0;
               neuron_d   = '0;
            end
         end
         LOAD: begin
            s_ready = 1'b1;
            busy    = 1'b1;
            if (s_valid) begin
               if (word_cnt_q == CNT_W'(N)) begin
                  state_d = WRITE;
               end else begin
                  word_cnt_d = word_cnt_q + CNT_W'(1);
               end
            end
         end
         WRITE: begin
            write_en   = 1'b1;
            busy       = 1'b1;
            word_cnt_d = '0;
            if (last_neuron && last_layer) begin
               state_d = DONE;
            end else begin
               state_d = LOAD;
               if (last_neuron) begin
                  neuron_d = '0;
                  layer_d  = layer_q + LA_W'(1);
               end else begin
                  neuron_d = neuron_q + NA_W'(1);
               end
            end
         end
         DONE: begin
            done    = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign layer_addr  = layer_q;
   assign neuron_addr = neuron_q;
   assign bias        = bias_q;

endmodule

// File: tb/tb_mlp_param_writer.sv
// Directed bench for mlp_param_writer: default instance plus a wide-bias instance
// (QM=4, QN=8) sharing the same stream to check bias sign extension.
module tb_mlp_param_writer;

   localparam int N = 3;

   logic clk;
   logic rst, start, s_valid;
   logic signed [7:0] s_data;

   logic s_ready_a, write_en_a, busy_a, done_a;
   logic [0:0] layer_a;
   logic [1:0] neuron_a;
   logic signed [7:0] w_row_a [N];
   logic signed [7:0] bias_a;

   logic s_ready_b, write_en_b, busy_b, done_b;
   logic [0:0] layer_b;
   logic [1:0] neuron_b;
   logic signed [7:0] w_row_b [N];
   logic signed [11:0] bias_b;

   typedef struct {
      int          cyc;
      logic [31:0] layer;
      logic [31:0] neuron;
      logic [31:0] w0, w1, w2;
      logic [31:0] ba;
      logic [31:0] bb;
   } exp_t;

   exp_t exp_tab [6];
   logic [7:0] words [24];
   int checks = 0;
   int failures = 0;

   mlp_param_writer #(.M(3), .N(3), .QM(3), .QN(5), .WM(3), .WN(5)) dut_a (
      .clk(clk), .rst(rst), .start(start), .s_valid(s_valid), .s_ready(s_ready_a),
      .s_data(s_data), .write_en(write_en_a), .layer_addr(layer_a), .neuron_addr(neuron_a),
      .w_row(w_row_a), .bias(bias_a), .busy(busy_a), .done(done_a)
   );

   mlp_param_writer #(.M(3), .N(3), .QM(4), .QN(8), .WM(3), .WN(5)) dut_b (
      .clk(clk), .rst(rst), .start(start), .s_valid(s_valid), .s_ready(s_ready_b),
      .s_data(s_data), .write_en(write_en_b), .layer_addr(layer_b), .neuron_addr(neuron_b),
      .w_row(w_row_b), .bias(bias_b), .busy(busy_b), .done(done_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] u8(input logic [7:0] v);
      return 32'(v);
   endfunction

   function automatic logic [31:0] u12(input logic [11:0] v);
      return 32'(v);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, expv);
      end
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_s_ready"}, 32'(s_ready_a), 32'd0);
      check({tag, "_write_en"}, 32'(write_en_a), 32'd0);
      check({tag, "_busy"}, 32'(busy_a), 32'd0);
      check({tag, "_done"}, 32'(done_a), 32'd0);
      check({tag, "_layer"}, 32'(layer_a), 32'd0);
      check({tag, "_neuron"}, 32'(neuron_a), 32'd0);
      check({tag, "_w0"}, u8(w_row_a[0]), 32'd0);
      check({tag, "_w1"}, u8(w_row_a[1]), 32'd0);
      check({tag, "_w2"}, u8(w_row_a[2]), 32'd0);
      check({tag, "_bias"}, u8(bias_a), 32'd0);
      check({tag, "_bias_b"}, u12(bias_b), 32'd0);
   endtask

   // Expected writes for a full load whose neurons each take 'period' cycles.
   task automatic fill_table(input int period);
      for (int k = 0; k < 6; k++) begin
         exp_tab[k].cyc    = period * (k + 1);
         exp_tab[k].layer  = 32'(k / 3);
         exp_tab[k].neuron = 32'(k % 3);
         exp_tab[k].w0     = u8(words[4*k]);
         exp_tab[k].w1     = u8(words[4*k+1]);
         exp_tab[k].w2     = u8(words[4*k+2]);
         exp_tab[k].ba     = u8(words[4*k+3]);
         exp_tab[k].bb     = u12({{4{words[4*k+3][7]}}, words[4*k+3]});
      end
   endtask

   // vmode 0: s_valid always 1; vmode 1: s_valid high in odd cycles only.
   // smode 1: stray start pulses in LOAD (3, 13) and WRITE (5, 15) cycles.
   // rst_at > 0: assert rst for the edge ending that cycle.
   task automatic run_load(input int vmode, input int smode, input int rst_at, input int period);
      int idx;
      int nwr;
      bit finished;
      fill_table(period);
      idx = 0;
      nwr = 0;
      finished = 1'b0;
      @(negedge clk);
      start   = 1'b1;
      s_valid = 1'b0;
      s_data  = '0;
      @(posedge clk);
      for (int c = 1; c <= 80; c++) begin
         @(negedge clk);
         if (write_en_a) begin
            if (nwr < 6) begin
               check("wr_cycle", 32'(c), 32'(exp_tab[nwr].cyc));
               check("wr_layer", 32'(layer_a), exp_tab[nwr].layer);
               check("wr_neuron", 32'(neuron_a), exp_tab[nwr].neuron);
               check("wr_w0", u8(w_row_a[0]), exp_tab[nwr].w0);
               check("wr_w1", u8(w_row_a[1]), exp_tab[nwr].w1);
               check("wr_w2", u8(w_row_a[2]), exp_tab[nwr].w2);
               check("wr_bias", u8(bias_a), exp_tab[nwr].ba);
               check("wr_bias_wide", u12(bias_b), exp_tab[nwr].bb);
               check("wr_b_strobe", 32'(write_en_b), 32'd1);
               check("wr_ready_low", 32'(s_ready_a), 32'd0);
               $display("write %0d cyc=%0d layer=%0d neuron=%0d row=%0d,%0d,%0d bias=%0h bias_wide=%0h",
                        nwr, c, layer_a, neuron_a, w_row_a[0], w_row_a[1], w_row_a[2], bias_a, bias_b);
            end else begin
               check("extra_write", 32'(nwr), 32'd5);
            end
            nwr++;
         end
         if (vmode == 1 && (c % 2) == 0 && (c % period) != 0 && c < 6 * period) begin
            check("ready_held", 32'(s_ready_a), 32'd1);
         end
         if (rst_at > 0 && c == rst_at + 1) begin
            check_reset_state("midrst");
         end
         if (rst_at > 0 && c > rst_at + 1) begin
            check("post_rst_no_write", 32'(write_en_a), 32'd0);
            check("post_rst_no_done", 32'(done_a), 32'd0);
         end
         if (rst_at > 0 && c == rst_at + 6) begin
            check("rst_write_count", 32'(nwr), 32'd4);
            finished = 1'b1;
         end
         if (done_a) begin
            check("done_cycle", 32'(c), 32'(6 * period + 1));
            check("write_count", 32'(nwr), 32'd6);
            check("done_busy_low", 32'(busy_a), 32'd0);
            $display("done cyc=%0d writes=%0d", c, nwr);
            finished = 1'b1;
         end
         if (finished) break;
         rst     = (rst_at > 0 && c == rst_at);
         start   = (smode == 1 && (c == 3 || c == 5 || c == 13 || c == 15));
         s_valid = (vmode == 0) ? 1'b1 : ((c % 2) == 1);
         s_data  = (idx < 24) ? words[idx] : 8'h00;
         if (s_valid && s_ready_a && idx < 24) idx++;
      end
      if (!finished) begin
         check("load_timeout", 32'd0, 32'd1);
      end
      rst     = 1'b0;
      start   = 1'b0;
      s_valid = 1'b0;
   endtask

   initial begin
      rst     = 1'b1;
      start   = 1'b0;
      s_valid = 1'b0;
      s_data  = '0;
      for (int i = 0; i < 24; i++) words[i] = 8'(i + 1);
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset_state("reset");
      rst = 1'b0;

      run_load(0, 0, 0, 5);   // continuous stream
      run_load(1, 0, 0, 8);   // toggled valid, started the cycle after done
      run_load(0, 1, 0, 5);   // stray start pulses
      run_load(0, 0, 23, 5);  // reset while word 2 of neuron (1,1) pending
      run_load(0, 0, 0, 5);   // reload from (0,0) after reset
      words[3] = 8'hF0;
      run_load(0, 0, 0, 5);   // negative bias, sign-extended on wide instance

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
